fpu_cpx_req_rcv: RTL

//  CPX-side receiver for FPU result requests. Captures the registered request
//  {core one-hot, thread, source pipe} in cycle N and the result data in N+1,

---
 rtl/fpu_cpx_req_rcv.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fpu_cpx_req_rcv.sv
// CPX-side receiver for FPU result requests.
// A request {core, thread, pipe} is captured in cycle N, joined with its result
// data in N+1 and pushed into a small FIFO whose head is offered to the CPX
// arbiter through a valid/grant handshake. Credits and sticky error flags are
// reported alongside.
module fpu_cpx_req_rcv #(
    parameter int unsigned DW    = 145,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = 2,
    parameter int unsigned CW    = 3
) (
    input  logic          rclk,
    input  logic          arst_l,
    input  logic [7:0]    fp_cpx_req_cq,
    input  logic [1:0]    req_thread,
    input  logic [2:0]    dest_rdy,
    input  logic [DW-1:0] fpu_cpx_data,
    input  logic          cpx_gnt,
    output logic          cpx_req_vld,
    output logic [7:0]    cpx_req_core,
    output logic [1:0]    cpx_req_thread,
    output logic [2:0]    cpx_req_pipe,
    output logic [DW-1:0] cpx_req_data,
    output logic [CW-1:0] fpu_credit,
    output logic          ovfl_err,
    output logic          proto_err
);

    // Capture stage
    logic          pend_vld_q;
    logic [7:0]    pend_core_q;
    logic [1:0]    pend_thread_q;
    logic [2:0]    pend_pipe_q;

    // FIFO storage and control
    logic [7:0]    mem_core   [DEPTH];
    logic [1:0]    mem_thread [DEPTH];
    logic [2:0]    mem_pipe   [DEPTH];
    logic [DW-1:0] mem_data   [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovfl_q, proto_q;

    logic req_any, req_ok, full, empty, push, pop, push_ok, drop;

    // Decode request legality and FIFO push/pop qualifiers
    always_comb begin
        req_any = |fp_cpx_req_cq;
        req_ok  = $onehot(fp_cpx_req_cq) && $onehot(dest_rdy);
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        pop     = !empty && cpx_gnt;
        push    = pend_vld_q;
        // A full FIFO still accepts a push when the head leaves on the same edge
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Capture well-formed requests; a malformed one is dropped with its data beat
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            pend_vld_q    <= 1'b0;
            pend_core_q   <= '0;
            pend_thread_q <= '0;
            pend_pipe_q   <= '0;
        end else begin
            pend_vld_q <= req_ok;
            if (req_ok) begin
                pend_core_q   <= fp_cpx_req_cq;
                pend_thread_q <= req_thread;
                pend_pipe_q   <= dest_rdy;
            end
        end
    end

    // FIFO entry storage; written at the tail on an accepted push
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_core[i]   <= '0;
                mem_thread[i] <= '0;
                mem_pipe[i]   <= '0;
                mem_data[i]   <= '0;
            end
        end else if (push_ok) begin
            mem_core[wr_ptr_q]   <= pend_core_q;
            mem_thread[wr_ptr_q] <= pend_thread_q;
            mem_pipe[wr_ptr_q]   <= pend_pipe_q;
            mem_data[wr_ptr_q]   <= fpu_cpx_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ovfl_q  <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            if (drop)               ovfl_q  <= 1'b1;
            if (req_any && !req_ok) proto_q <= 1'b1;
        end
    end

    // Head presented straight from storage; zeroed while empty
    always_comb begin
        cpx_req_vld    = !empty;
        cpx_req_core   = empty ? '0 : mem_core[rd_ptr_q];
        cpx_req_thread = empty ? '0 : mem_thread[rd_ptr_q];
        cpx_req_pipe   = empty ? '0 : mem_pipe[rd_ptr_q];
        cpx_req_data   = empty ? '0 : mem_data[rd_ptr_q];
        fpu_credit     = CW'(DEPTH) - count_q;
        ovfl_err       = ovfl_q;
        proto_err      = proto_q;
    end

endmodule
